// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/execute sequencer that owns
// the PC register load path and the imem request handshake.
module pc_sequencer #(
   parameter int unsigned ADDR_W = 20,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned FETCH_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              halt_req,
   input  logic              imem_ack,
   input  logic              exec_done,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_target,
   input  logic [ADDR_W-1:0] pc_cur,
   output logic              pc_load,
   output logic [ADDR_W-1:0] pc_next,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              decode_en,
   output logic              exec_en,
   output logic              halted,
   output logic              fault,
   output logic [15:0]       retired
);

   typedef enum logic [2:0] {
      st_init,
      st_idle,
      st_fetch,
      st_decode,
      st_exec,
      st_update,
      st_halt,
      st_fault
   } state_t;

   localparam logic [7:0] tlast = 8'(FETCH_TIMEOUT - 1);

   state_t            state;
   state_t            nxt;
   logic [ADDR_W-1:0] npc;
   logic [7:0]        tcnt;
   logic              halt_pending;

   assign pc_next = npc;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= st_init;
      else        state <= nxt;
   end

   // next-state decode and Moore outputs
   always_comb begin
      nxt       = state;
      pc_load   = 1'b0;
      imem_req  = 1'b0;
      imem_addr = '0;
      decode_en = 1'b0;
      exec_en   = 1'b0;
      halted    = 1'b0;
      fault     = 1'b0;
      unique case (state)
         st_init: begin
            pc_load = 1'b1;
            nxt     = st_idle;
         end
         st_idle: begin
            if (halt_pending) nxt = st_halt;
            else if (start)   nxt = st_fetch;
         end
         st_fetch: begin
            imem_req  = 1'b1;
            imem_addr = pc_cur;
            if (imem_ack)           nxt = st_decode;
            else if (tcnt == tlast) nxt = st_fault;
         end
         st_decode: begin
            decode_en = 1'b1;
            nxt       = st_exec;
         end
         st_exec: begin
            exec_en = 1'b1;
            if (exec_done) nxt = st_update;
         end
         st_update: begin
            pc_load = 1'b1;
            nxt     = halt_pending ? st_halt : st_fetch;
         end
         st_halt: begin
            halted = 1'b1;
            if (start) nxt = st_fetch;
         end
         st_fault: begin
            fault = 1'b1;
         end
         default: nxt = st_init;
      endcase
   end

   // fetch timeout counter, restarts on every FETCH entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         tcnt <= '0;
      else if (state != st_fetch)         tcnt <= '0;
      else if (!imem_ack && tcnt != tlast) tcnt <= tcnt + 8'd1;
   end

   // next PC captured when execute completes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         npc <= RESET_PC;
      end else if (state == st_exec && exec_done) begin
         npc <= redirect_valid ? redirect_target
                               : pc_cur + ADDR_W'(1);
      end
   end

   // sticky halt request, dropped once HALT is entered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halt_pending <= 1'b0;
      end else if (nxt == st_halt && state != st_halt) begin
         halt_pending <= 1'b0;
      end else if (halt_req && state != st_halt
                   && state != st_fault) begin
         halt_pending <= 1'b1;
      end
   end

   // saturating count of retired instructions
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired <= '0;
      end else if (state == st_update && retired != 16'hFFFF) begin
         retired <= retired + 16'd1;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer
// with a behavioural PC register closing the loop.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        halt_req;
   logic        imem_ack;
   logic        exec_done;
   logic        redirect_valid;
   logic [19:0] redirect_target;
   logic [19:0] pc_cur;
   logic        pc_load;
   logic [19:0] pc_next;
   logic        imem_req;
   logic [19:0] imem_addr;
   logic        decode_en;
   logic        exec_en;
   logic        halted;
   logic        fault;
   logic [15:0] retired;

   logic [19:0] pc_reg = 20'h12345;
   logic [19:0] exp_q[$];
   logic [19:0] model_pc;
   int          model_ret;
   int          total = 0;
   int          bad = 0;
   logic        req_d = 1'b0;

   assign pc_cur = pc_reg;

   pc_sequencer #(
      .ADDR_W(20),
      .RESET_PC(20'h00000),
      .FETCH_TIMEOUT(16)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .halt_req(halt_req),
      .imem_ack(imem_ack),
      .exec_done(exec_done),
      .redirect_valid(redirect_valid),
      .redirect_target(redirect_target),
      .pc_cur(pc_cur),
      .pc_load(pc_load),
      .pc_next(pc_next),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .decode_en(decode_en),
      .exec_en(exec_en),
      .halted(halted),
      .fault(fault),
      .retired(retired)
   );

   always #5 clk = ~clk;

   // PC register driven by the sequencer
   always @(posedge clk) begin
      if (pc_load) pc_reg <= pc_next;
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // each new fetch pops the expected address
   always @(negedge clk) begin
      if (imem_req && !req_d) begin
         chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0)
            chk("fetch_addr", imem_addr, exp_q.pop_front());
      end
      req_d = imem_req;
   end

   task automatic exec_instr(input logic rv,
                             input logic [19:0] tgt,
                             input logic nack);
      logic [19:0] nxt;
      redirect_valid  = rv;
      redirect_target = tgt;
      nxt = rv ? tgt : model_pc + 20'd1;
      tick();
      chk("dec_en", decode_en, 1);
      chk("req_off", imem_req, 0);
      chk("load_d", pc_load, 0);
      tick();
      chk("exec_en", exec_en, 1);
      chk("load_e", pc_load, 0);
      tick();
      chk("load_u", pc_load, 1);
      chk("pc_next", pc_next, nxt);
      model_ret++;
      exp_q.push_back(nxt);
      imem_ack = nack;
      tick();
      chk("retired", retired, model_ret);
      model_pc = nxt;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      halt_req = 1'b0;
      imem_ack = 1'b0;
      exec_done = 1'b0;
      redirect_valid = 1'b0;
      redirect_target = '0;
      model_ret = 0;
      model_pc = '0;
      tick();
      tick();
      chk("rst_load", pc_load, 1);
      chk("rst_pcn", pc_next, 0);
      chk("rst_req", imem_req, 0);
      chk("rst_dec", decode_en, 0);
      chk("rst_exe", exec_en, 0);
      chk("rst_hlt", halted, 0);
      chk("rst_flt", fault, 0);
      chk("rst_ret", retired, 0);
      rst_n = 1'b1;
      tick();
      chk("idle_pc", pc_cur, 0);
      chk("idle_load", pc_load, 0);

      start = 1'b1;
      imem_ack = 1'b1;
      exec_done = 1'b1;
      exp_q.push_back(20'h00000);
      tick();
      chk("fetch0_load", pc_load, 0);
      start = 1'b0;
      exec_instr(0, '0, 1);
      exec_instr(0, '0, 1);
      exec_instr(0, '0, 0);
      chk("pc_seq3", pc_cur, 3);

      for (int k = 2; k <= 6; k++) begin
         tick();
         chk("stall_req", imem_req, 1);
      end
      imem_ack = 1'b1;
      exec_instr(1, 20'h00010, 1);
      exec_instr(1, 20'h0ABCD, 1);
      exec_instr(1, 20'hFFFFF, 1);
      exec_instr(0, '0, 1);
      chk("wrap_pc", pc_cur, 0);

      tick();
      tick();
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      chk("halt_upd", pc_load, 1);
      model_ret++;
      tick();
      chk("halted", halted, 1);
      chk("halt_ret", retired, model_ret);
      chk("halt_pc", pc_cur, 1);
      chk("halt_req", imem_req, 0);
      tick();
      chk("halt_hold", halted, 1);
      model_pc = 20'h00001;
      exp_q.push_back(model_pc);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("resume", halted, 0);

      exec_done = 1'b0;
      tick();
      tick();
      chk("exec_wait0", exec_en, 1);
      tick();
      chk("exec_wait1", exec_en, 1);
      redirect_valid = 1'b1;
      redirect_target = 20'h00777;
      exec_done = 1'b1;
      #3;
      rst_n = 1'b0;
      #1;
      model_ret = 0;
      chk("arst_load", pc_load, 1);
      chk("arst_pcn", pc_next, 0);
      chk("arst_exe", exec_en, 0);
      chk("arst_ret", retired, 0);
      chk("arst_req", imem_req, 0);
      chk("arst_hlt", halted, 0);
      exec_done = 1'b0;
      redirect_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("arst_pc", pc_cur, 0);
      chk("arst_ret2", retired, 0);

      start = 1'b1;
      imem_ack = 1'b0;
      exec_done = 1'b1;
      exp_q.push_back(20'h00000);
      tick();
      start = 1'b0;
      for (int c = 2; c <= 16; c++) tick();
      chk("lastack_req", imem_req, 1);
      chk("lastack_flt", fault, 0);
      imem_ack = 1'b1;
      tick();
      chk("lastack_dec", decode_en, 1);
      chk("lastack_flt2", fault, 0);
      imem_ack = 1'b0;
      exp_q.push_back(20'h00001);
      tick();
      tick();
      tick();
      for (int c = 2; c <= 16; c++) tick();
      chk("to16_flt", fault, 0);
      chk("to16_req", imem_req, 1);
      tick();
      chk("to17_flt", fault, 1);
      chk("to17_req", imem_req, 0);
      start = 1'b1;
      imem_ack = 1'b1;
      tick();
      tick();
      chk("flt_sticky", fault, 1);
      chk("flt_req", imem_req, 0);
      start = 1'b0;
      tick();

      chk("sb_drain", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
